// File: rtl/ifu.sv
// Instruction fetch unit: PC register, bus fetch, redirect drain and IF/ID register.
// Optional IFU_MISALIGN_CHECK_EN adds the if_misaligned output and suppresses misaligned fetches.
`timescale 1ns/1ps
module ifu #(
  parameter int unsigned       XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ibus_read,
  output logic [XLEN-1:0] ibus_address,
  input  logic            ibus_waitrequest,
  input  logic [31:0]     ibus_readdata,
  input  logic            if_flush,
  input  logic            if_stall,
  input  logic            branch_take,
  input  logic [XLEN-1:0] branch_target,
  input  logic            trap_take,
  input  logic [XLEN-1:0] trap_target,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instruction,
  output logic            id_valid
`ifdef IFU_MISALIGN_CHECK_EN
  ,
  output logic            if_misaligned
`endif
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pend_pc;
  logic [XLEN-1:0] redirect_target;
  logic            redirect;
  logic            accepted;
  logic            bus_busy;
  logic            misaligned_pc;

  assign redirect        = trap_take | branch_take;
  assign redirect_target = trap_take ? trap_target : branch_target;

`ifdef IFU_MISALIGN_CHECK_EN
  assign misaligned_pc = (pc[1:0] != 2'b00);
`else
  assign misaligned_pc = 1'b0;
`endif

  assign ibus_address = pc;
  assign ibus_read    = ~rst & ~misaligned_pc;
  assign accepted     = ibus_read & ~ibus_waitrequest;
  // Only an outstanding request has to be drained; an idle bus can redirect at once.
  assign bus_busy     = ibus_read & ibus_waitrequest;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      pc             <= RESET_VECTOR;
      pend_pc        <= '0;
      id_valid       <= 1'b0;
      id_pc          <= '0;
      id_instruction <= 32'h0000_0013;
`ifdef IFU_MISALIGN_CHECK_EN
      if_misaligned  <= 1'b0;
`endif
    end else begin
      case (state)
        RUN: begin
          if (redirect) begin
            if (bus_busy) begin
              pend_pc <= redirect_target;
              state   <= DRAIN;
            end else begin
              pc <= redirect_target;
            end
          end else if (accepted && !if_stall) begin
            pc <= pc + XLEN'(4);
          end
        end
        DRAIN: begin
          if (redirect) pend_pc <= redirect_target;
          if (!bus_busy) begin
            // A redirect arriving in the final drain cycle is the newest one and wins.
            pc    <= redirect ? redirect_target : pend_pc;
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase

      if (if_flush || redirect || state == DRAIN) begin
        id_valid      <= 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
        if_misaligned <= 1'b0;
`endif
      end else if (!if_stall) begin
        id_pc          <= pc;
        id_instruction <= ibus_readdata;
        id_valid       <= accepted | misaligned_pc;
`ifdef IFU_MISALIGN_CHECK_EN
        if_misaligned  <= misaligned_pc;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: table of per-cycle vectors plus scoreboard of captured fetches.
`timescale 1ns/1ps
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ibus_read;
  logic [31:0] ibus_address;
  logic        ibus_waitrequest;
  logic [31:0] ibus_readdata;
  logic        if_flush;
  logic        if_stall;
  logic        branch_take;
  logic [31:0] branch_target;
  logic        trap_take;
  logic [31:0] trap_target;
  logic [31:0] id_pc;
  logic [31:0] id_instruction;
  logic        id_valid;
`ifdef IFU_MISALIGN_CHECK_EN
  logic        if_misaligned;
`endif

  ifu #(.XLEN(32), .RESET_VECTOR(32'h100)) dut (
    .clk              (clk),
    .rst              (rst),
    .ibus_read        (ibus_read),
    .ibus_address     (ibus_address),
    .ibus_waitrequest (ibus_waitrequest),
    .ibus_readdata    (ibus_readdata),
    .if_flush         (if_flush),
    .if_stall         (if_stall),
    .branch_take      (branch_take),
    .branch_target    (branch_target),
    .trap_take        (trap_take),
    .trap_target      (trap_target),
    .id_pc            (id_pc),
    .id_instruction   (id_instruction),
    .id_valid         (id_valid)
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    .if_misaligned    (if_misaligned)
`endif
  );

  always #5 clk = ~clk;

  // One clock cycle: inputs, address expected before the edge, capture and id_valid after it.
  typedef struct {
    logic        w;
    logic        st;
    logic        fl;
    logic        br;
    logic [31:0] bt;
    logic        tr;
    logic [31:0] tt;
    logic [31:0] addr;
    logic        cap;
    logic        val;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } cap_t;

  vec_t tbl[$];
  cap_t sbq[$];
  cap_t last;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    ibus_waitrequest = 1'b0;
    if_flush         = 1'b0;
    if_stall         = 1'b0;
    branch_take      = 1'b0;
    branch_target    = '0;
    trap_take        = 1'b0;
    trap_target      = '0;
    ibus_readdata    = 32'h0000_0013;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    chk("ibus_address", ibus_address, v.addr);
    chk("ibus_read", 32'(ibus_read), 32'd1);
    ibus_waitrequest = v.w;
    if_stall         = v.st;
    if_flush         = v.fl;
    branch_take      = v.br;
    branch_target    = v.bt;
    trap_take        = v.tr;
    trap_target      = v.tt;
    ibus_readdata    = $urandom;
    if (v.cap) sbq.push_back('{v.addr, ibus_readdata});
    @(posedge clk);
    #1;
    if (v.cap && sbq.size() > 0) last = sbq.pop_front();
    chk("id_valid", 32'(id_valid), 32'(v.val));
    if (v.val) begin
      chk("id_pc", id_pc, last.pc);
      chk("id_instruction", id_instruction, last.instr);
    end
  endtask

  initial begin
    //            w  st fl br bt            tr tt        addr          cap val
    tbl.push_back('{0, 0, 0, 0, 32'h0,        0, 32'h0,   32'h100,      1, 1});
    tbl.push_back('{0, 0, 0, 0, 32'h0,        0, 32'h0,   32'h104,      1, 1});
    tbl.push_back('{0, 0, 0, 0, 32'h0,        0, 32'h0,   32'h108,      1, 1});
    tbl.push_back('{0, 0, 0, 1, 32'h200,      0, 32'h0,   32'h10C,      0, 0});
    tbl.push_back('{1, 1, 1, 0, 32'h0,        0, 32'h0,   32'h200,      0, 0});
    tbl.push_back('{1, 1, 1, 0, 32'h0,        0, 32'h0,   32'h200,      0, 0});
    tbl.push_back('{1, 1, 1, 0, 32'h0,        0, 32'h0,   32'h200,      0, 0});
    tbl.push_back('{0, 0, 0, 0, 32'h0,        0, 32'h0,   32'h200,      1, 1});
    tbl.push_back('{0, 0, 0, 0, 32'h0,        0, 32'h0,   32'h204,      1, 1});
    tbl.push_back('{0, 0, 0, 1, 32'h300,      0, 32'h0,   32'h208,      0, 0});
    tbl.push_back('{1, 0, 0, 1, 32'h400,      0, 32'h0,   32'h300,      0, 0});
    tbl.push_back('{1, 0, 0, 0, 32'h0,        0, 32'h0,   32'h300,      0, 0});
    tbl.push_back('{0, 0, 0, 0, 32'h0,        0, 32'h0,   32'h300,      0, 0});
    tbl.push_back('{0, 0, 0, 0, 32'h0,        0, 32'h0,   32'h400,      1, 1});
    tbl.push_back('{0, 0, 0, 1, 32'h500,      1, 32'h80,  32'h404,      0, 0});
    tbl.push_back('{0, 0, 0, 0, 32'h0,        0, 32'h0,   32'h80,       1, 1});
    tbl.push_back('{0, 0, 0, 1, 32'h10,       0, 32'h0,   32'h84,       0, 0});
    tbl.push_back('{0, 0, 0, 0, 32'h0,        0, 32'h0,   32'h10,       1, 1});
    tbl.push_back('{0, 1, 0, 0, 32'h0,        0, 32'h0,   32'h14,       0, 1});
    tbl.push_back('{0, 1, 0, 0, 32'h0,        0, 32'h0,   32'h14,       0, 1});
    tbl.push_back('{0, 0, 0, 0, 32'h0,        0, 32'h0,   32'h14,       1, 1});
    tbl.push_back('{0, 0, 0, 0, 32'h0,        0, 32'h0,   32'h18,       1, 1});
    tbl.push_back('{1, 0, 0, 1, 32'h600,      0, 32'h0,   32'h1C,       0, 0});
    tbl.push_back('{1, 0, 0, 0, 32'h0,        1, 32'h700, 32'h1C,       0, 0});
    tbl.push_back('{0, 0, 0, 0, 32'h0,        0, 32'h0,   32'h1C,       0, 0});
    tbl.push_back('{0, 0, 0, 0, 32'h0,        0, 32'h0,   32'h700,      1, 1});
    tbl.push_back('{0, 0, 0, 1, 32'hFFFFFFFC, 0, 32'h0,   32'h704,      0, 0});
    tbl.push_back('{0, 0, 0, 0, 32'h0,        0, 32'h0,   32'hFFFFFFFC, 1, 1});
    tbl.push_back('{0, 0, 0, 0, 32'h0,        0, 32'h0,   32'h0,        1, 1});
    tbl.push_back('{0, 1, 1, 0, 32'h0,        0, 32'h0,   32'h4,        0, 0});
    tbl.push_back('{0, 0, 0, 0, 32'h0,        0, 32'h0,   32'h4,        1, 1});
    tbl.push_back('{0, 1, 0, 1, 32'h900,      0, 32'h0,   32'h8,        0, 0});
    tbl.push_back('{0, 0, 0, 0, 32'h0,        0, 32'h0,   32'h900,      1, 1});

    drive_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst ibus_read", 32'(ibus_read), 32'd0);
    chk("rst ibus_address", ibus_address, 32'h100);
    chk("rst id_valid", 32'(id_valid), 32'd0);
    chk("rst id_pc", id_pc, 32'h0);
    chk("rst id_instruction", id_instruction, 32'h0000_0013);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

`ifdef IFU_MISALIGN_CHECK_EN
    apply('{0, 0, 0, 0, 32'h0, 1, 32'h82, 32'h904, 0, 0});
    @(negedge clk);
    chk("misalign ibus_read", 32'(ibus_read), 32'd0);
    chk("misalign ibus_address", ibus_address, 32'h82);
    drive_idle();
    @(posedge clk);
    #1;
    chk("if_misaligned set", 32'(if_misaligned), 32'd1);
    chk("misalign id_valid", 32'(id_valid), 32'd1);
    chk("misalign id_pc", id_pc, 32'h82);
    @(negedge clk);
    branch_take   = 1'b1;
    branch_target = 32'h904;
    @(posedge clk);
    #1;
    chk("if_misaligned clear", 32'(if_misaligned), 32'd0);
    chk("redirect id_valid", 32'(id_valid), 32'd0);
`endif

    // Enter DRAIN, then reset: the pending redirect to 0x2000 must be dropped.
    apply('{1, 0, 0, 1, 32'h2000, 0, 32'h0, 32'h904, 0, 0});
    @(negedge clk);
    drive_idle();
    ibus_waitrequest = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("drain rst ibus_read", 32'(ibus_read), 32'd0);
    chk("drain rst ibus_address", ibus_address, 32'h100);
    chk("drain rst id_valid", 32'(id_valid), 32'd0);
    chk("drain rst id_instruction", id_instruction, 32'h0000_0013);
    @(negedge clk);
    ibus_waitrequest = 1'b0;
    @(posedge clk);
    #1;
    chk("drain rst hold address", ibus_address, 32'h100);
    rst = 1'b0;
    apply('{0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h100, 1, 1});
    apply('{0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h104, 1, 1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
